// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command width, NOP encoding and arbiter state type
package cmd_pkg;
  localparam int CMD_W = 16;
  localparam logic [CMD_W-1:0] CMD_NOP = '0;
  typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_A, ARB_HOLD_B} arb_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: power-of-two command FIFO with flush; full/empty come from the count only
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = CMD_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_pop, do_push;
  assign do_pop = pop && cnt_q != '0;
  assign do_push = push && (cnt_q != CW'(DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: arbitrates UART and diag command words into a FIFO feeding cmd_proc
module cmd_sched
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIM = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] a_cmd,
  input  logic             a_rdy,
  output logic             a_clr,
  input  logic [CMD_W-1:0] b_cmd,
  input  logic             b_rdy,
  output logic             b_clr,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             flush,
  output logic [CW-1:0]    q_cnt,
  output logic [7:0]       drop_cnt
);
  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] drop_q, drop_d;
  logic [CMD_W-1:0] win_cmd, fifo_dout;
  logic a_elig, b_elig, go, grant_a, grant_b, nop, push;
  always_comb begin
    a_elig = a_rdy && state_q != ARB_HOLD_A;
    b_elig = b_rdy && state_q != ARB_HOLD_B;
    go = !flush && (q_cnt != CW'(DEPTH) || clr_cmd_rdy);
    grant_a = go && a_elig && (!b_elig || starve_q >= 4'(STARVE_LIM));
    grant_b = go && b_elig && !grant_a;
    win_cmd = grant_a ? a_cmd : b_cmd;
    nop = win_cmd == CMD_NOP;
    push = (grant_a || grant_b) && !nop;
    state_d = grant_a ? ARB_HOLD_A : grant_b ? ARB_HOLD_B : ARB_IDLE;
    starve_d = (!a_rdy || grant_a) ? 4'd0
             : (a_elig && grant_b && starve_q != 4'hF) ? starve_q + 4'd1 : starve_q;
    drop_d = ((grant_a || grant_b) && nop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      starve_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      drop_q <= drop_d;
    end
  end
  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(clr_cmd_rdy),
    .flush(flush),
    .din(win_cmd),
    .dout(fifo_dout),
    .count(q_cnt)
  );
  assign a_clr = state_q == ARB_HOLD_A;
  assign b_clr = state_q == ARB_HOLD_B;
  assign cmd_rdy = q_cnt != '0;
  assign cmd = cmd_rdy ? fifo_dout : CMD_NOP;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: directed scenarios plus randomized run against a queue-based reference model
module tb_cmd_sched;
  localparam int DEPTH = 4;
  localparam int LIM = 3;
  logic clk = 0, rst_n = 0;
  logic [15:0] a_cmd = 0, b_cmd = 0, cmd;
  logic a_rdy = 0, b_rdy = 0, clr_cmd_rdy = 0, flush = 0;
  logic a_clr, b_clr, cmd_rdy;
  logic [2:0] q_cnt;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] mq[$];
  bit m_aclr, m_bclr;
  int m_starve, m_drop;

  cmd_sched #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .a_cmd(a_cmd), .a_rdy(a_rdy), .a_clr(a_clr),
    .b_cmd(b_cmd), .b_rdy(b_rdy), .b_clr(b_clr), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .flush(flush), .q_cnt(q_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    bit a_el, b_el, room, ga, gb;
    logic [15:0] w;
    a_el = a_rdy && !m_aclr;
    b_el = b_rdy && !m_bclr;
    room = mq.size() < DEPTH || clr_cmd_rdy;
    ga = 0;
    gb = 0;
    if (room && !flush) begin
      if (a_el && b_el) begin
        if (m_starve >= LIM) ga = 1; else gb = 1;
      end else if (a_el) ga = 1;
      else if (b_el) gb = 1;
    end
    w = ga ? a_cmd : b_cmd;
    if (!rst_n) begin
      mq.delete();
      m_aclr = 0;
      m_bclr = 0;
      m_starve = 0;
      m_drop = 0;
    end else begin
      if (!a_rdy || ga) m_starve = 0;
      else if (a_el && gb && m_starve < 15) m_starve++;
      if (flush) mq.delete();
      else begin
        if (clr_cmd_rdy && mq.size() > 0) void'(mq.pop_front());
        if ((ga || gb) && w != 0) mq.push_back(w);
      end
      if ((ga || gb) && w == 0 && m_drop < 255) m_drop++;
      m_aclr = ga;
      m_bclr = gb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; a_rdy = 0; b_rdy = 0; clr_cmd_rdy = 0; flush = 0;
    step();
    rst_n = 1;
  endtask

  task automatic fill_b(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      b_cmd = base + 16'(k);
      b_rdy = 1;
      step();
      step();
    end
    b_rdy = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_cmp++; if (a_clr !== 1'b0) begin n_fail++; $display("FAIL reset_a_clr got=%0h want=0", a_clr); end
    n_cmp++; if (b_clr !== 1'b0) begin n_fail++; $display("FAIL reset_b_clr got=%0h want=0", b_clr); end
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_rdy got=%0h want=0", cmd_rdy); end
    n_cmp++; if (q_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_q_cnt got=%0d want=0", q_cnt); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    n_cmp++; if (cmd !== 16'h0) begin n_fail++; $display("FAIL reset_cmd got=%h want=0000", cmd); end
  endtask

  task automatic test_single_a();
    do_reset();
    a_cmd = 16'h00F6;
    a_rdy = 1;
    step();
    n_cmp++; if (a_clr !== 1'b1) begin n_fail++; $display("FAIL single_a_clr got=%0h want=1", a_clr); end
    n_cmp++; if (cmd !== 16'h00F6) begin n_fail++; $display("FAIL single_cmd got=%h want=00f6", cmd); end
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL single_cmd_rdy got=%0h want=1", cmd_rdy); end
    n_cmp++; if (q_cnt !== 3'd1) begin n_fail++; $display("FAIL single_q_cnt got=%0d want=1", q_cnt); end
    step();
    a_rdy = 0;
    n_cmp++; if (a_clr !== 1'b0) begin n_fail++; $display("FAIL single_a_clr_pulse got=%0h want=0", a_clr); end
    n_cmp++; if (q_cnt !== 3'd1) begin n_fail++; $display("FAIL single_holdoff_q got=%0d want=1", q_cnt); end
    clr_cmd_rdy = 1;
    step();
    clr_cmd_rdy = 0;
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL single_pop_rdy got=%0h want=0", cmd_rdy); end
    n_cmp++; if (cmd !== 16'h0) begin n_fail++; $display("FAIL single_pop_cmd got=%h want=0000", cmd); end
  endtask

  task automatic test_alternate();
    do_reset();
    a_cmd = 16'h1111; b_cmd = 16'h2222;
    a_rdy = 1; b_rdy = 1; clr_cmd_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (b_clr !== (i % 2 == 0)) begin n_fail++; $display("FAIL alt_b_clr[%0d] got=%0h want=%0h", i, b_clr, i % 2 == 0); end
      n_cmp++; if (a_clr !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_a_clr[%0d] got=%0h want=%0h", i, a_clr, i % 2 == 1); end
      n_cmp++; if (cmd !== ((i % 2 == 0) ? 16'h2222 : 16'h1111)) begin n_fail++; $display("FAIL alt_cmd[%0d] got=%h", i, cmd); end
    end
    a_rdy = 0; b_rdy = 0; clr_cmd_rdy = 0;
  endtask

  task automatic test_fill_wrap();
    logic [15:0] w [5];
    do_reset();
    for (int k = 0; k < 5; k++) w[k] = 16'hB000 + 16'(k);
    for (int k = 0; k < 4; k++) begin
      b_cmd = w[k];
      b_rdy = 1;
      step();
      n_cmp++; if (b_clr !== 1'b1 || q_cnt !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_push[%0d] got=%0h/%0d want=1/%0d", k, b_clr, q_cnt, k + 1); end
      step();
    end
    b_cmd = w[4];
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (b_clr !== 1'b0 || q_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_full[%0d] got=%0h/%0d want=0/4", k, b_clr, q_cnt); end
    end
    clr_cmd_rdy = 1;
    step();
    clr_cmd_rdy = 0;
    b_rdy = 0;
    n_cmp++; if (b_clr !== 1'b1 || q_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_pushpop got=%0h/%0d want=1/4", b_clr, q_cnt); end
    for (int k = 1; k < 5; k++) begin
      n_cmp++; if (cmd !== w[k] || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_order[%0d] got=%h want=%h", k, cmd, w[k]); end
      clr_cmd_rdy = 1;
      step();
      clr_cmd_rdy = 0;
    end
    n_cmp++; if (cmd_rdy !== 1'b0 || q_cnt !== 3'd0) begin n_fail++; $display("FAIL fill_drained got=%0h/%0d want=0/0", cmd_rdy, q_cnt); end
  endtask

  task automatic test_starve();
    do_reset();
    fill_b(4, 16'hC000);
    a_cmd = 16'hAAAA; a_rdy = 1;
    b_cmd = 16'hBBBB; b_rdy = 1;
    step();
    step();
    for (int r = 0; r < 4; r++) begin
      clr_cmd_rdy = 1;
      step();
      clr_cmd_rdy = 0;
      n_cmp++; if (b_clr !== (r < 3)) begin n_fail++; $display("FAIL starve_b_clr[%0d] got=%0h want=%0h", r, b_clr, r < 3); end
      n_cmp++; if (a_clr !== (r == 3)) begin n_fail++; $display("FAIL starve_a_clr[%0d] got=%0h want=%0h", r, a_clr, r == 3); end
      step();
      step();
    end
    a_rdy = 0; b_rdy = 0;
  endtask

  task automatic test_nop();
    do_reset();
    a_cmd = 16'h0000;
    a_rdy = 1;
    step();
    n_cmp++; if (a_clr !== 1'b1) begin n_fail++; $display("FAIL nop_a_clr got=%0h want=1", a_clr); end
    n_cmp++; if (q_cnt !== 3'd0) begin n_fail++; $display("FAIL nop_q_cnt got=%0d want=0", q_cnt); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL nop_drop1 got=%0d want=1", drop_cnt); end
    repeat (640) step();
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL nop_drop_sat got=%0d want=255", drop_cnt); end
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL nop_cmd_rdy got=%0h want=0", cmd_rdy); end
    a_rdy = 0;
    step();
  endtask

  task automatic test_flush();
    do_reset();
    fill_b(3, 16'hD000);
    n_cmp++; if (q_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_pre_q got=%0d want=3", q_cnt); end
    a_cmd = 16'hA5A5; a_rdy = 1; flush = 1;
    step();
    flush = 0;
    n_cmp++; if (q_cnt !== 3'd0 || cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_clear got=%0d/%0h want=0/0", q_cnt, cmd_rdy); end
    n_cmp++; if (a_clr !== 1'b0) begin n_fail++; $display("FAIL flush_no_grant got=%0h want=0", a_clr); end
    step();
    a_rdy = 0;
    n_cmp++; if (a_clr !== 1'b1 || q_cnt !== 3'd1 || cmd !== 16'hA5A5) begin n_fail++; $display("FAIL flush_after got=%0h/%0d/%h want=1/1/a5a5", a_clr, q_cnt, cmd); end
    step();
  endtask

  task automatic test_midreset();
    do_reset();
    fill_b(1, 16'hE000);
    b_cmd = 16'hE001; b_rdy = 1;
    step();
    n_cmp++; if (b_clr !== 1'b1 || q_cnt !== 3'd2) begin n_fail++; $display("FAIL mrst_pre got=%0h/%0d want=1/2", b_clr, q_cnt); end
    rst_n = 0;
    step();
    rst_n = 1;
    b_rdy = 0;
    n_cmp++; if ({a_clr, b_clr, cmd_rdy} !== 3'b0 || q_cnt !== 3'd0 || cmd !== 16'h0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mrst_outputs got=%b/%0d/%h/%0d want=0", {a_clr, b_clr, cmd_rdy}, q_cnt, cmd, drop_cnt);
    end
    b_cmd = 16'hC3C3; b_rdy = 1;
    step();
    b_rdy = 0;
    n_cmp++; if (b_clr !== 1'b1 || cmd !== 16'hC3C3) begin n_fail++; $display("FAIL mrst_idle got=%0h/%h want=1/c3c3", b_clr, cmd); end
    step();
  endtask

  task automatic test_random();
    bit a_done = 0, b_done = 0;
    logic [15:0] exp_cmd;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_aclr) a_done = 1;
      else if (a_done || !a_rdy) begin
        a_rdy = $urandom_range(0, 2) != 0;
        a_cmd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        a_done = 0;
      end
      if (m_bclr) b_done = 1;
      else if (b_done || !b_rdy) begin
        b_rdy = $urandom_range(0, 2) != 0;
        b_cmd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        b_done = 0;
      end
      clr_cmd_rdy = 1'($urandom_range(0, 1));
      flush = $urandom_range(0, 29) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      step();
      exp_cmd = (mq.size() > 0) ? mq[0] : 16'h0;
      n_cmp++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL rnd_cmd[%0d] got=%h want=%h", i, cmd, exp_cmd); end
      n_cmp++; if (q_cnt !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_q_cnt[%0d] got=%0d want=%0d", i, q_cnt, mq.size()); end
      n_cmp++; if (cmd_rdy !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_cmd_rdy[%0d] got=%0h", i, cmd_rdy); end
      n_cmp++; if (a_clr !== m_aclr) begin n_fail++; $display("FAIL rnd_a_clr[%0d] got=%0h want=%0h", i, a_clr, m_aclr); end
      n_cmp++; if (b_clr !== m_bclr) begin n_fail++; $display("FAIL rnd_b_clr[%0d] got=%0h want=%0h", i, b_clr, m_bclr); end
      n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop[%0d] got=%0d want=%0d", i, drop_cnt, m_drop); end
    end
    rst_n = 1; flush = 0; clr_cmd_rdy = 0; a_rdy = 0; b_rdy = 0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_alternate();
    test_fill_wrap();
    test_starve();
    test_nop();
    test_flush();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
